// File: rtl/id_ex_lanes_pkg.sv
// Shared constants and edge-mode decode for the multi-lane ID/EX pipeline register.
// Extends the single-issue defines with active-low reset and lane-mode helpers.
package id_ex_lanes_pkg;

  localparam logic [7:0] EXE_NOP_OP     = 8'h00;
  localparam logic [2:0] EXE_RES_NOP    = 3'b000;
  localparam logic [4:0] NOPRegAddr     = 5'b00000;
  localparam logic       Stop           = 1'b1;
  localparam logic       NoStop         = 1'b0;
  localparam logic       WriteEnable    = 1'b1;
  localparam logic       WriteDisable   = 1'b0;
  localparam logic       InDelaySlot    = 1'b1;
  localparam logic       NotInDelaySlot = 1'b0;
  localparam logic       RstEnable_n    = 1'b0;

  typedef enum logic [1:0] {
    MODE_CAPTURE,
    MODE_BUBBLE,
    MODE_HOLD,
    MODE_FLUSH
  } edge_mode_e;

  // Flush wins over any stall pattern; an upstream-only stall inserts a bubble.
  function automatic edge_mode_e decode_mode(input logic flush,
                                             input logic stall_id,
                                             input logic stall_ex);
    if (flush)
      return MODE_FLUSH;
    if (stall_id == Stop)
      return (stall_ex == Stop) ? MODE_HOLD : MODE_BUBBLE;
    return MODE_CAPTURE;
  endfunction

endpackage

// File: rtl/id_ex_lane.sv
// One issue lane of the ID/EX register: payload storage with capture, bubble
// and flush behaviour selected by the shared edge mode.
module id_ex_lane
  import id_ex_lanes_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUOP_W   = 8,
  parameter int ALUSEL_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  edge_mode_e           mode,
  input  logic                 id_valid,
  input  logic                 id_kill,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [ALUSEL_W-1:0]  id_alusel,
  input  logic [DATA_W-1:0]    id_reg1,
  input  logic [DATA_W-1:0]    id_reg2,
  input  logic [DATA_W-1:0]    id_offset,
  input  logic [REGADDR_W-1:0] id_wd,
  input  logic                 id_wreg,
  output logic                 ex_valid,
  output logic                 ex_wreg,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [ALUSEL_W-1:0]  ex_alusel,
  output logic [DATA_W-1:0]    ex_reg1,
  output logic [DATA_W-1:0]    ex_reg2,
  output logic [DATA_W-1:0]    ex_offset,
  output logic [REGADDR_W-1:0] ex_wd
);

  logic lane_live;
  assign lane_live = id_valid & ~id_kill;

  // A killed or empty lane must never leave a write-back target behind.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable_n) begin
      ex_valid  <= 1'b0;
      ex_wreg   <= WriteDisable;
      ex_aluop  <= ALUOP_W'(EXE_NOP_OP);
      ex_alusel <= ALUSEL_W'(EXE_RES_NOP);
      ex_reg1   <= '0;
      ex_reg2   <= '0;
      ex_offset <= '0;
      ex_wd     <= REGADDR_W'(NOPRegAddr);
    end else begin
      unique case (mode)
        MODE_FLUSH: begin
          ex_valid  <= 1'b0;
          ex_wreg   <= WriteDisable;
          ex_aluop  <= ALUOP_W'(EXE_NOP_OP);
          ex_alusel <= ALUSEL_W'(EXE_RES_NOP);
          ex_wd     <= REGADDR_W'(NOPRegAddr);
        end
        MODE_BUBBLE: begin
          ex_valid <= 1'b0;
          ex_wreg  <= WriteDisable;
          ex_wd    <= REGADDR_W'(NOPRegAddr);
        end
        MODE_HOLD: ;
        default: begin
          ex_valid  <= lane_live;
          ex_wreg   <= id_wreg & lane_live;
          ex_aluop  <= id_aluop;
          ex_alusel <= id_alusel;
          ex_reg1   <= id_reg1;
          ex_reg2   <= id_reg2;
          ex_offset <= id_offset;
          ex_wd     <= lane_live ? id_wd : REGADDR_W'(NOPRegAddr);
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ex_lanes.sv
// Multi-lane ID/EX pipeline register: stall decode, lane-0 delay-slot flags.
// Define ID_EX_PERF_EN to add bubble_cnt/hold_cnt performance counters.
module id_ex_lanes
  import id_ex_lanes_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUOP_W   = 8,
  parameter int ALUSEL_W  = 3,
  parameter int STALL_W   = 6,
  parameter int STAGE     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STALL_W-1:0]         stall,
  input  logic                       flush,
  input  logic [LANES-1:0]           id_valid,
  input  logic [LANES-1:0]           id_kill,
  input  logic [LANES*ALUOP_W-1:0]   id_aluop,
  input  logic [LANES*ALUSEL_W-1:0]  id_alusel,
  input  logic [LANES*DATA_W-1:0]    id_reg1,
  input  logic [LANES*DATA_W-1:0]    id_reg2,
  input  logic [LANES*DATA_W-1:0]    id_offset,
  input  logic [LANES*REGADDR_W-1:0] id_wd,
  input  logic [LANES-1:0]           id_wreg,
  input  logic                       next_inst_in_delayslot_i,
  input  logic                       id_is_delayslot_i,
  output logic [LANES-1:0]           ex_valid,
  output logic [LANES-1:0]           ex_wreg,
  output logic [LANES*ALUOP_W-1:0]   ex_aluop,
  output logic [LANES*ALUSEL_W-1:0]  ex_alusel,
  output logic [LANES*DATA_W-1:0]    ex_reg1,
  output logic [LANES*DATA_W-1:0]    ex_reg2,
  output logic [LANES*DATA_W-1:0]    ex_offset,
  output logic [LANES*REGADDR_W-1:0] ex_wd,
`ifdef ID_EX_PERF_EN
  output logic [31:0]                bubble_cnt,
  output logic [31:0]                hold_cnt,
`endif
  output logic                       is_delayslot_o,
  output logic                       ex_is_in_delayslot_o
);

  edge_mode_e mode;
  logic       stall_unused;

  // Only this register's two stall taps matter; the rest of the vector is ignored.
  assign stall_unused = ^stall;

  always_comb begin
    mode = decode_mode(flush, stall[STAGE], stall[STAGE+1]);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    id_ex_lane #(
      .DATA_W   (DATA_W),
      .REGADDR_W(REGADDR_W),
      .ALUOP_W  (ALUOP_W),
      .ALUSEL_W (ALUSEL_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .id_valid (id_valid[i]),
      .id_kill  (id_kill[i]),
      .id_aluop (id_aluop[i*ALUOP_W +: ALUOP_W]),
      .id_alusel(id_alusel[i*ALUSEL_W +: ALUSEL_W]),
      .id_reg1  (id_reg1[i*DATA_W +: DATA_W]),
      .id_reg2  (id_reg2[i*DATA_W +: DATA_W]),
      .id_offset(id_offset[i*DATA_W +: DATA_W]),
      .id_wd    (id_wd[i*REGADDR_W +: REGADDR_W]),
      .id_wreg  (id_wreg[i]),
      .ex_valid (ex_valid[i]),
      .ex_wreg  (ex_wreg[i]),
      .ex_aluop (ex_aluop[i*ALUOP_W +: ALUOP_W]),
      .ex_alusel(ex_alusel[i*ALUSEL_W +: ALUSEL_W]),
      .ex_reg1  (ex_reg1[i*DATA_W +: DATA_W]),
      .ex_reg2  (ex_reg2[i*DATA_W +: DATA_W]),
      .ex_offset(ex_offset[i*DATA_W +: DATA_W]),
      .ex_wd    (ex_wd[i*REGADDR_W +: REGADDR_W])
    );
  end

  // Delay-slot flags follow lane 0 only; a bubble keeps the pending next-slot hint.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable_n) begin
      is_delayslot_o       <= NotInDelaySlot;
      ex_is_in_delayslot_o <= NotInDelaySlot;
    end else begin
      unique case (mode)
        MODE_FLUSH: begin
          is_delayslot_o       <= NotInDelaySlot;
          ex_is_in_delayslot_o <= NotInDelaySlot;
        end
        MODE_BUBBLE: ex_is_in_delayslot_o <= NotInDelaySlot;
        MODE_HOLD: ;
        default: begin
          is_delayslot_o       <= next_inst_in_delayslot_i;
          ex_is_in_delayslot_o <= id_is_delayslot_i;
        end
      endcase
    end
  end

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable_n) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      if (mode == MODE_BUBBLE)
        bubble_cnt <= bubble_cnt + 32'd1;
      if (mode == MODE_HOLD)
        hold_cnt <= hold_cnt + 32'd1;
    end
  end
`endif

  illegal_stall_a: assert property (@(posedge clk) disable iff (rst == RstEnable_n)
    !(flush == 1'b0 && stall[STAGE] == NoStop && stall[STAGE+1] == Stop));

endmodule

// File: tb/tb_id_ex_lanes.sv
// Self-checking bench for id_ex_lanes (two lanes): directed plan steps followed
// by randomized traffic compared against a per-lane reference model.
module tb_id_ex_lanes;

  localparam int LANES = 2, DATA_W = 32, REGADDR_W = 5, ALUOP_W = 8;
  localparam int ALUSEL_W = 3, STALL_W = 6, STAGE = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [STALL_W-1:0]         stall;
  logic                       flush;
  logic [LANES-1:0]           id_valid, id_kill, id_wreg;
  logic [LANES*ALUOP_W-1:0]   id_aluop;
  logic [LANES*ALUSEL_W-1:0]  id_alusel;
  logic [LANES*DATA_W-1:0]    id_reg1, id_reg2, id_offset;
  logic [LANES*REGADDR_W-1:0] id_wd;
  logic                       next_inst_in_delayslot_i, id_is_delayslot_i;
  logic [LANES-1:0]           ex_valid, ex_wreg;
  logic [LANES*ALUOP_W-1:0]   ex_aluop;
  logic [LANES*ALUSEL_W-1:0]  ex_alusel;
  logic [LANES*DATA_W-1:0]    ex_reg1, ex_reg2, ex_offset;
  logic [LANES*REGADDR_W-1:0] ex_wd;
  logic                       is_delayslot_o, ex_is_in_delayslot_o;
`ifdef ID_EX_PERF_EN
  logic [31:0]                bubble_cnt, hold_cnt;
`endif

  id_ex_lanes #(
    .LANES(LANES), .DATA_W(DATA_W), .REGADDR_W(REGADDR_W), .ALUOP_W(ALUOP_W),
    .ALUSEL_W(ALUSEL_W), .STALL_W(STALL_W), .STAGE(STAGE)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_kill(id_kill), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_offset(id_offset), .id_wd(id_wd),
    .id_wreg(id_wreg), .next_inst_in_delayslot_i(next_inst_in_delayslot_i),
    .id_is_delayslot_i(id_is_delayslot_i),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_offset(ex_offset), .ex_wd(ex_wd),
`ifdef ID_EX_PERF_EN
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt),
`endif
    .is_delayslot_o(is_delayslot_o), .ex_is_in_delayslot_o(ex_is_in_delayslot_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: what each lane's EX side should hold after the next edge.
  logic                 m_valid  [LANES];
  logic                 m_wreg   [LANES];
  logic [ALUOP_W-1:0]   m_aluop  [LANES];
  logic [ALUSEL_W-1:0]  m_alusel [LANES];
  logic [DATA_W-1:0]    m_reg1   [LANES];
  logic [DATA_W-1:0]    m_reg2   [LANES];
  logic [DATA_W-1:0]    m_offset [LANES];
  logic [REGADDR_W-1:0] m_wd     [LANES];
  logic                 m_isds, m_exds;
  logic [31:0]          m_bub, m_hold;

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int l = 0; l < LANES; l++) begin
      m_valid[l] = 0; m_wreg[l] = 0; m_aluop[l] = '0; m_alusel[l] = '0;
      m_reg1[l] = '0; m_reg2[l] = '0; m_offset[l] = '0; m_wd[l] = '0;
    end
    m_isds = 0; m_exds = 0; m_bub = 0; m_hold = 0;
  endtask

  task automatic modelStep();
    bit up_stalled, down_stalled;
    up_stalled   = stall[STAGE];
    down_stalled = stall[STAGE+1];
    if (flush) begin
      for (int l = 0; l < LANES; l++) begin
        m_valid[l] = 0; m_wreg[l] = 0; m_wd[l] = '0; m_aluop[l] = '0; m_alusel[l] = '0;
      end
      m_isds = 0; m_exds = 0;
    end else if (up_stalled && !down_stalled) begin
      for (int l = 0; l < LANES; l++) begin
        m_valid[l] = 0; m_wreg[l] = 0; m_wd[l] = '0;
      end
      m_exds = 0;
      m_bub  = m_bub + 1;
    end else if (up_stalled) begin
      m_hold = m_hold + 1;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        m_valid[l]  = id_valid[l] && !id_kill[l];
        m_wreg[l]   = id_wreg[l] && m_valid[l];
        m_aluop[l]  = id_aluop[l*ALUOP_W +: ALUOP_W];
        m_alusel[l] = id_alusel[l*ALUSEL_W +: ALUSEL_W];
        m_reg1[l]   = id_reg1[l*DATA_W +: DATA_W];
        m_reg2[l]   = id_reg2[l*DATA_W +: DATA_W];
        m_offset[l] = id_offset[l*DATA_W +: DATA_W];
        m_wd[l]     = m_valid[l] ? id_wd[l*REGADDR_W +: REGADDR_W] : '0;
      end
      m_isds = next_inst_in_delayslot_i;
      m_exds = id_is_delayslot_i;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [LANES-1:0]           e_valid, e_wreg;
    logic [LANES*ALUOP_W-1:0]   e_aluop;
    logic [LANES*ALUSEL_W-1:0]  e_alusel;
    logic [LANES*DATA_W-1:0]    e_reg1, e_reg2, e_offset;
    logic [LANES*REGADDR_W-1:0] e_wd;
    for (int l = 0; l < LANES; l++) begin
      e_valid[l] = m_valid[l];
      e_wreg[l]  = m_wreg[l];
      e_aluop[l*ALUOP_W +: ALUOP_W]    = m_aluop[l];
      e_alusel[l*ALUSEL_W +: ALUSEL_W] = m_alusel[l];
      e_reg1[l*DATA_W +: DATA_W]       = m_reg1[l];
      e_reg2[l*DATA_W +: DATA_W]       = m_reg2[l];
      e_offset[l*DATA_W +: DATA_W]     = m_offset[l];
      e_wd[l*REGADDR_W +: REGADDR_W]   = m_wd[l];
    end
    checkVal({tag, ".valid"},  ex_valid,  e_valid);
    checkVal({tag, ".wreg"},   ex_wreg,   e_wreg);
    checkVal({tag, ".aluop"},  ex_aluop,  e_aluop);
    checkVal({tag, ".alusel"}, ex_alusel, e_alusel);
    checkVal({tag, ".reg1"},   ex_reg1,   e_reg1);
    checkVal({tag, ".reg2"},   ex_reg2,   e_reg2);
    checkVal({tag, ".offset"}, ex_offset, e_offset);
    checkVal({tag, ".wd"},     ex_wd,     e_wd);
    checkVal({tag, ".isds"},   is_delayslot_o,       m_isds);
    checkVal({tag, ".exds"},   ex_is_in_delayslot_o, m_exds);
`ifdef ID_EX_PERF_EN
    checkVal({tag, ".bubble_cnt"}, bubble_cnt, m_bub);
    checkVal({tag, ".hold_cnt"},   hold_cnt,   m_hold);
`endif
  endtask

  task automatic randPayload();
    id_valid  = LANES'($urandom);
    id_kill   = ($urandom_range(0, 3) == 0) ? LANES'($urandom) : '0;
    id_wreg   = LANES'($urandom);
    id_aluop  = (LANES*ALUOP_W)'($urandom);
    id_alusel = (LANES*ALUSEL_W)'($urandom);
    id_reg1   = {$urandom, $urandom};
    id_reg2   = {$urandom, $urandom};
    id_offset = {$urandom, $urandom};
    id_wd     = (LANES*REGADDR_W)'($urandom);
    next_inst_in_delayslot_i = 1'($urandom);
    id_is_delayslot_i        = 1'($urandom);
  endtask

  // Inputs change on the falling edge; the model advances for the rising edge in between.
  task automatic applyStimulus(input logic fl, input logic [STALL_W-1:0] st);
    flush = fl;
    stall = st;
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    logic [STALL_W-1:0] st;
    rst = 1'b1;
    flush = 1'b0;
    stall = '0;
    randPayload();
    #1 rst = 1'b0;
    modelReset();
    #1 checkOutput("reset");
    checkVal("reset.aluop_nop", ex_aluop, '0);
    @(negedge clk);
    rst = 1'b1;

    id_valid = 2'b11; id_kill = 2'b10; id_wreg = 2'b11; id_wd = {5'd7, 5'd3};
    applyStimulus(1'b0, 6'b000000);
    checkOutput("capture");
    checkVal("capture.valid_const", ex_valid, 2'b01);
    checkVal("capture.wreg_const",  ex_wreg,  2'b01);
    checkVal("capture.wd_const",    ex_wd,    {5'd0, 5'd3});

    randPayload();
    id_valid = 2'b11; id_kill = 2'b00;
    id_reg1[DATA_W-1:0] = 32'h1234;
    applyStimulus(1'b0, 6'b000000);
    checkOutput("pre_bubble");
    randPayload();
    applyStimulus(1'b0, 6'b000100);
    checkOutput("bubble");
    checkVal("bubble.reg1_const", ex_reg1[DATA_W-1:0], 32'h1234);
    checkVal("bubble.valid_const", ex_valid, 2'b00);

    for (int k = 0; k < 3; k++) begin
      randPayload();
      applyStimulus(1'b0, 6'b001100);
      checkOutput("hold");
    end

    randPayload();
    id_is_delayslot_i = 1'b1;
    applyStimulus(1'b1, 6'b001100);
    checkOutput("flush");
    checkVal("flush.isds_const", is_delayslot_o, 1'b0);

    randPayload();
    next_inst_in_delayslot_i = 1'b1; id_is_delayslot_i = 1'b0;
    applyStimulus(1'b0, 6'b000000);
    checkOutput("ds1");
    checkVal("ds1.isds_const", is_delayslot_o, 1'b1);
    next_inst_in_delayslot_i = 1'b0; id_is_delayslot_i = 1'b1;
    applyStimulus(1'b0, 6'b000000);
    checkOutput("ds2");
    checkVal("ds2.exds_const", ex_is_in_delayslot_o, 1'b1);

    for (int k = 0; k < 4; k++) begin
      randPayload();
      applyStimulus(1'b0, 6'b000000);
    end
    stall = 6'b001100;
    #2 rst = 1'b0;
    modelReset();
    #1 checkOutput("async_reset");
    @(negedge clk);
    rst = 1'b1;
    randPayload();
    applyStimulus(1'b0, 6'b000100);
    checkOutput("post_reset_bubble");

    for (int k = 0; k < 400; k++) begin
      randPayload();
      st = STALL_W'($urandom);
      if (!st[STAGE]) st[STAGE+1] = 1'b0;
      applyStimulus(($urandom_range(0, 7) == 0), st);
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
